fpu_add_normalize: RTL and testbench



---
 rtl/fpu_pkg.sv | 19 +
 rtl/lzc_24.sv | 16 +
 rtl/fpu_add_normalize.sv | 184 ++++++++++++++++++
 tb/tb_fpu_add_normalize.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared widths, constants and the packed binary32 layout for the FP adder.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SUM_W    = MAN_W + 2;   // hidden bit plus carry-out
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      POS_INF = 32'h7F800000;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

endpackage

// File: rtl/lzc_24.sv
// Combinational 24-bit leading-zero counter; count is 24 when value is all zero.
module lzc_24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);

    // Scan from LSB upward so the highest set bit writes last and wins.
    // NOTE: count gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) count = 5'(23 - i);
        end
    end

endmodule

// File: rtl/fpu_add_normalize.sv
// Normalize / round / pack stage of the binary32 adder, 2-stage valid/ready pipeline.
// Build option: define FPU_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fpu_add_normalize
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SUM_W-1:0] in_sum,
    input  logic [2:0]       in_grs,
    input  logic             in_special,
    input  logic [31:0]      in_special_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inexact
);

    // ---------------- handshake ----------------
    logic s1_valid, s2_valid;
    logic s1_load, s2_load;

    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // ---------------- stage 1: normalize ----------------
    logic [4:0]       lz;
    logic [4:0]       shift;
    logic [EXP_W-1:0] exp_m1;
    logic [MAN_W+2:0] shifted;        // {sum[23:0], G, R}
    logic [EXP_W:0]   n_exp;          // one extra bit so a carry past 254 is visible
    logic [MAN_W:0]   n_mant;
    logic             n_g, n_r, n_s, n_zero;

    lzc_24 u_lzc (
        .value (in_sum[MAN_W:0]),
        .count (lz)
    );

    assign exp_m1 = in_exp - 8'd1;
    assign n_zero = (in_sum == '0) && (in_grs == 3'b000);

    // Carry-out shifts right once; otherwise shift left by leading zeros, clamped at exponent 1.
    always_comb begin
        shift   = '0;
        shifted = '0;
        n_exp   = {1'b0, in_exp};
        n_mant  = in_sum[MAN_W:0];
        n_g     = in_grs[2];
        n_r     = in_grs[1];
        n_s     = in_grs[0];
        if (in_sum[SUM_W-1]) begin
            n_mant = in_sum[SUM_W-1:1];
            n_g    = in_sum[0];
            n_r    = in_grs[2];
            n_s    = in_grs[1] | in_grs[0];
            n_exp  = {1'b0, in_exp} + 9'd1;
        end else begin
            shift   = ({3'b000, lz} > exp_m1) ? exp_m1[4:0] : lz;
            shifted = {in_sum[MAN_W:0], in_grs[2:1]} << shift;
            n_mant  = shifted[MAN_W+2:2];
            n_g     = shifted[1];
            n_r     = shifted[0];
            n_s     = in_grs[0];
            n_exp   = {1'b0, in_exp} - {4'b0000, shift};
        end
    end

    logic             s1_sign, s1_special, s1_zero;
    logic [31:0]      s1_special_val;
    logic [EXP_W:0]   s1_exp;
    logic [MAN_W:0]   s1_mant;
    logic             s1_g, s1_r, s1_s;

    // Stage-1 register: loads whenever it is empty or its beat moves into stage 2.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: data registers are reset along with the valids so the outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid       <= 1'b0;
            s1_sign        <= 1'b0;
            s1_special     <= 1'b0;
            s1_zero        <= 1'b0;
            s1_special_val <= '0;
            s1_exp         <= '0;
            s1_mant        <= '0;
            s1_g           <= 1'b0;
            s1_r           <= 1'b0;
            s1_s           <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign        <= in_sign;
                s1_special     <= in_special;
                s1_zero        <= n_zero;
                s1_special_val <= in_special_val;
                s1_exp         <= n_exp;
                s1_mant        <= n_mant;
                s1_g           <= n_g;
                s1_r           <= n_r;
                s1_s           <= n_s;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [MAN_W+1:0] m25;
    logic [MAN_W:0]   mant_r;
    logic [EXP_W:0]   exp_r;
    fp32_t            r_result;
    logic             r_ovf, r_unf, r_inexact;

`ifdef FPU_RNE_EN
    logic round_up;
    assign round_up = s1_g & (s1_r | s1_s | s1_mant[0]);
    assign m25      = {1'b0, s1_mant} + {{(MAN_W+1){1'b0}}, round_up};
`else
    assign m25      = {1'b0, s1_mant};
`endif

    // Renormalize a rounding carry, then choose overflow, subnormal or normal packing.
    always_comb begin
        mant_r    = m25[MAN_W:0];
        exp_r     = s1_exp;
        if (m25[MAN_W+1]) begin
            mant_r = m25[MAN_W+1:1];
            exp_r  = s1_exp + 9'd1;
        end
        r_inexact = s1_g | s1_r | s1_s;
        r_ovf     = 1'b0;
        r_unf     = 1'b0;
        r_result  = '0;
        if (s1_special) begin
            r_result  = s1_special_val;
            r_inexact = 1'b0;
        end else if (s1_zero) begin
            r_result = '0;
        end else if (exp_r >= {1'b0, EXP_MAX}) begin
            r_result = '{sign: s1_sign, exp: EXP_MAX, man: '0};
            r_ovf    = 1'b1;
        end else begin
            // Tininess is judged on the normalized, unrounded mantissa.
            r_unf    = !s1_mant[MAN_W] & r_inexact;
            r_result = '{sign: s1_sign,
                         exp:  mant_r[MAN_W] ? exp_r[EXP_W-1:0] : '0,
                         man:  mant_r[MAN_W-1:0]};
        end
    end

    fp32_t s2_result;
    logic  s2_ovf, s2_unf, s2_inexact;

    // Stage-2 register: holds the packed result stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_ovf     <= 1'b0;
            s2_unf     <= 1'b0;
            s2_inexact <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result  <= r_result;
                s2_ovf     <= r_ovf;
                s2_unf     <= r_unf;
                s2_inexact <= r_inexact;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_ovf     = s2_ovf;
    assign out_unf     = s2_unf;
    assign out_inexact = s2_inexact;

endmodule

// File: tb/tb_fpu_add_normalize.sv
// Self-checking bench for fpu_add_normalize: directed cases plus random traffic
// against a loop-based reference model and an in-order scoreboard.
module tb_fpu_add_normalize;
    import fpu_pkg::*;

    typedef logic [34:0] res_t;   // {result, ovf, unf, inexact}

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign, in_special;
    logic [7:0]  in_exp;
    logic [24:0] in_sum;
    logic [2:0]  in_grs;
    logic [31:0] in_special_val;
    logic        out_valid, out_ready, out_ovf, out_unf, out_inexact;
    logic [31:0] out_result;

    int   errors = 0;
    int   checks = 0;
    res_t exp_q[$];
    logic stall_prev = 1'b0;
    res_t held;

    always #5 clk = ~clk;

    fpu_add_normalize dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign        (in_sign),
        .in_exp         (in_exp),
        .in_sum         (in_sum),
        .in_grs         (in_grs),
        .in_special     (in_special),
        .in_special_val (in_special_val),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_ovf        (out_ovf),
        .out_unf        (out_unf),
        .out_inexact    (out_inexact)
    );

    task automatic check(input string tag, input res_t got, input res_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Reference: walk the value bit by bit instead of counting zeros.
    function automatic res_t model(input logic sign, input logic [7:0] exp_in,
                                   input logic [24:0] sum, input logic [2:0] grs,
                                   input logic special, input logic [31:0] sval);
        int          e;
        int          n;
        logic [26:0] x;
        logic        st, g, r, inexact, tiny, up;
        int unsigned m;
        logic [7:0]  ef;
        if (special) return {sval, 3'b000};
        if (sum == '0 && grs == 3'b000) return '0;
        e  = int'(exp_in);
        x  = {sum, grs[2:1]};
        st = grs[0];
        if (x[26]) begin
            st = st | x[0];
            x  = x >> 1;
            e++;
        end else begin
            n = 0;
            while (!x[25] && e > 1 && n < 24) begin
                x = x << 1;
                e--;
                n++;
            end
        end
        m       = 32'(x[25:2]);
        g       = x[1];
        r       = x[0];
        inexact = g | r | st;
        tiny    = (m < 32'h0080_0000);
`ifdef FPU_RNE_EN
        up = g & (r | st | m[0]);
`else
        up = 1'b0;
`endif
        m = m + 32'(up);
        if (m == 32'h0100_0000) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {sign, 8'hFF, 23'h0, 1'b1, 1'b0, inexact};
        ef = (m >= 32'h0080_0000) ? 8'(e) : 8'h00;
        return {sign, ef, m[22:0], 1'b0, tiny & inexact, inexact};
    endfunction

    // One cycle: sample #1 after the falling edge, score handshakes, wait for next falling edge.
    task automatic step();
        res_t obs;
        #1;
        obs = {out_result, out_ovf, out_unf, out_inexact};
        if (stall_prev) check("hold", obs, held);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 35'(out_valid), 35'(0));
            else                   check("result", obs, exp_q.pop_front());
        end
        if (in_valid && in_ready)
            exp_q.push_back(model(in_sign, in_exp, in_sum, in_grs, in_special, in_special_val));
        stall_prev = out_valid && !out_ready;
        held       = obs;
        @(negedge clk);
    endtask

    task automatic set_beat(input logic sign, input logic [7:0] e, input logic [24:0] sum,
                            input logic [2:0] grs);
        in_valid       = 1'b1;
        in_sign        = sign;
        in_exp         = e;
        in_sum         = sum;
        in_grs         = grs;
        in_special     = 1'b0;
        in_special_val = '0;
    endtask

    task automatic rand_beat();
        case ($urandom_range(0, 4))
            0:       in_sum = {1'b1, 24'($urandom)};
            1:       in_sum = {2'b01, 23'($urandom)};
            2:       in_sum = 25'($urandom) >> $urandom_range(1, 24);
            3:       in_sum = 25'($urandom_range(0, 3));
            default: in_sum = 25'($urandom) & 25'h0FF_FFFF;
        endcase
        case ($urandom_range(0, 2))
            0:       in_exp = 8'($urandom_range(1, 30));
            1:       in_exp = 8'($urandom_range(240, 254));
            default: in_exp = 8'($urandom_range(1, 254));
        endcase
        in_sign        = 1'($urandom);
        in_grs         = 3'($urandom);
        in_special     = ($urandom_range(0, 15) == 0);
        in_special_val = $urandom;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        check("drain_empty", 35'(exp_q.size()), 35'(0));
    endtask

    // Single beat into an empty pipe: checks 2-cycle latency and the absolute result.
    task automatic directed(input string tag, input logic sign, input logic [7:0] e,
                            input logic [24:0] sum, input logic [2:0] grs,
                            input logic [31:0] want, input logic want_ovf,
                            input logic want_inx);
        drain();
        set_beat(sign, e, sum, grs);
        step();
        in_valid = 1'b0;
        #1 check({tag, "_lat1"}, 35'(out_valid), 35'(0));
        step();
        #1 check({tag, "_lat2"}, 35'(out_valid), 35'(1));
        check({tag, "_val"}, {out_result, out_ovf, 1'b0, out_inexact},
              {want, want_ovf, 1'b0, want_inx});
        step();
    endtask

    logic acc;

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_sign        = 1'b0;
        in_exp         = 8'd1;
        in_sum         = '0;
        in_grs         = '0;
        in_special     = 1'b0;
        in_special_val = '0;
        out_ready      = 1'b1;
        #1;
        check("rst_in_ready", 35'(in_ready), 35'(1));
        check("rst_out", {out_result, out_valid, out_ovf, out_unf}, 35'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        directed("one_plus_one", 1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0);
        directed("cancel",       1'b0, 8'd127, 25'h0000001, 3'b000, 32'h34000000, 1'b0, 1'b0);
`ifdef FPU_RNE_EN
        directed("tie",          1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b1);
`else
        directed("tie",          1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800001, 1'b0, 1'b1);
`endif
        directed("overflow",     1'b0, 8'd254, 25'h1FFFFFF, 3'b111, POS_INF,      1'b1, 1'b1);
        directed("neg_zero",     1'b1, 8'd127, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0);
        directed("clamp_subn",   1'b0, 8'd3,   25'h0000100, 3'b000, 32'h00000400, 1'b0, 1'b0);
        drain();
        in_special = 1'b1; in_special_val = QNAN; in_valid = 1'b1;
        in_sum = 25'h1FFFFFF; in_grs = 3'b111; in_exp = 8'd254;
        step();
        in_valid = 1'b0; in_special = 1'b0;
        drain();

        // Backpressure: three beats against a stalled consumer for four cycles.
        out_ready = 1'b0;
        set_beat(1'b0, 8'd127, 25'h0900000, 3'b010); step();
        set_beat(1'b1, 8'd100, 25'h1234567, 3'b110); step();
        set_beat(1'b0, 8'd5,   25'h0000ABC, 3'b001);
        #1 check("bp_full", 35'(in_ready), 35'(0));
        step();
        #1 check("bp_full2", 35'(in_ready), 35'(0));
        step();
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 5 && !acc; i++) begin
            #1 acc = in_ready;
            step();
        end
        check("bp_accept", 35'(acc), 35'(1));
        drain();

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        set_beat(1'b0, 8'd127, 25'h0C00000, 3'b000); step();
        set_beat(1'b0, 8'd127, 25'h0A00000, 3'b000); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("flush_out_valid", 35'(out_valid), 35'(0));
        check("flush_in_ready",  35'(in_ready),  35'(1));
        check("flush_result",    35'(out_result), 35'(0));
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("post_reset_idle", 35'(out_valid), 35'(0));

        // Random traffic with random valid and ready.
        for (int i = 0; i < 600; i++) begin
            rand_beat();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
